// File: rtl/hud_pkg.sv
// hud_pkg: shared types and constants for the HUD statistics engine.
//   hud_state_t   - game-phase FSM encoding
//   bcd_digit_t   - one BCD nibble (0..9)
//   BCD_MAX_DIGIT - largest legal BCD digit
//   LEVEL_FIRST   - level value loaded at reset / game start
//   clamp_amount  - limits a binary award to a single BCD digit
package hud_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        PLAY      = 2'd2,
        GAME_OVER = 2'd3
    } hud_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
    localparam logic [7:0] LEVEL_FIRST   = 8'h01;

    // Awards above 9 are taken as 9 so the units adder never sees a non-BCD addend.
    function automatic bcd_digit_t clamp_amount(input logic [3:0] value);
        return (value > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : value;
    endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// bcd_digit_adder: combinational single-digit BCD adder.
//   a, b  - BCD digit operands (0..9)
//   cin   - decimal carry in
//   sum   - BCD result digit
//   cout  - decimal carry out
module bcd_digit_adder
    import hud_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t sum,
    output logic       cout
);

    logic [4:0] raw;

    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        sum  = raw[3:0];
        cout = 1'b0;
        // Binary sum above 9 wraps by subtracting ten and carries into the next digit.
        if (raw > 5'd9) begin
            sum  = 4'(raw - 5'd10);
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/hud_stats_counter.sv
// hud_stats_counter: game-statistics engine feeding the HUD digit packer.
// Holds lives, level, score and the pre-level countdown as BCD and runs the
// game-phase FSM (IDLE -> COUNTDOWN -> PLAY -> GAME_OVER).
//   clk, reset        - clock, synchronous active-high reset
//   startOfFrame      - per-frame tick, paces the countdown
//   gameStart         - start/restart request (IDLE, GAME_OVER only)
//   scoreAdd/Amount   - award pulse and its binary points (clamped to 9)
//   levelUp           - level complete pulse
//   lifeLost/lifeGain - life change pulses
//   *Display          - BCD outputs (lives 1, level 2, score 3, countdown 1 digit)
//   playing, goPulse, gameOver - phase flags, all registered
module hud_stats_counter
    import hud_pkg::*;
#(
    parameter int INIT_LIVES      = 3,
    parameter int MAX_LIVES       = 9,
    parameter int COUNTDOWN_START = 3,
    parameter int FRAMES_PER_SEC  = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        gameStart,
    input  logic        scoreAdd,
    input  logic [3:0]  scoreAmount,
    input  logic        levelUp,
    input  logic        lifeLost,
    input  logic        lifeGain,
    output logic [3:0]  livesDisplay,
    output logic [7:0]  levelDisplay,
    output logic [11:0] scoreDisplay,
    output logic [3:0]  countdownDisplay,
    output logic        playing,
    output logic        goPulse,
    output logic        gameOver
);

    localparam int         FCW          = $clog2(FRAMES_PER_SEC);
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAMES_PER_SEC - 1);
    localparam bcd_digit_t LIVES_INIT   = 4'(INIT_LIVES);
    localparam bcd_digit_t LIVES_MAX    = 4'(MAX_LIVES);
    localparam bcd_digit_t CD_START     = 4'(COUNTDOWN_START);

    hud_state_t      state_reg;
    bcd_digit_t      lives_reg;
    logic [7:0]      level_reg;
    logic [11:0]     score_reg;
    bcd_digit_t      countdown_reg;
    logic [FCW-1:0]  frame_reg;
    logic            playing_reg;
    logic            go_pulse_reg;
    logic            game_over_reg;

    // ---------------- score: three chained digit adders ----------------
    bcd_digit_t amount;
    bcd_digit_t score_d0, score_d1, score_d2;
    logic       score_c0, score_c1, score_c2;
    logic [11:0] score_next;

    assign amount = clamp_amount(scoreAmount);

    bcd_digit_adder u_score_units (
        .a(score_reg[3:0]),  .b(amount), .cin(1'b0),
        .sum(score_d0), .cout(score_c0)
    );
    bcd_digit_adder u_score_tens (
        .a(score_reg[7:4]),  .b(4'd0),   .cin(score_c0),
        .sum(score_d1), .cout(score_c1)
    );
    bcd_digit_adder u_score_hundreds (
        .a(score_reg[11:8]), .b(4'd0),   .cin(score_c1),
        .sum(score_d2), .cout(score_c2)
    );

    // A carry out of the hundreds digit means the true total passed 999.
    assign score_next = score_c2 ? 12'h999 : {score_d2, score_d1, score_d0};

    // ---------------- level: two-digit increment ----------------
    bcd_digit_t level_d0, level_d1;
    logic       level_c0, level_c1;
    logic [7:0] level_next;

    bcd_digit_adder u_level_units (
        .a(level_reg[3:0]), .b(4'd0), .cin(1'b1),
        .sum(level_d0), .cout(level_c0)
    );
    bcd_digit_adder u_level_tens (
        .a(level_reg[7:4]), .b(4'd0), .cin(level_c0),
        .sum(level_d1), .cout(level_c1)
    );

    assign level_next = level_c1 ? 8'h99 : {level_d1, level_d0};

    // Last life lost (and not cancelled by a simultaneous gain) ends the game
    // and takes priority over a same-cycle levelUp.
    logic lose_final;
    assign lose_final = lifeLost && !lifeGain && (lives_reg == 4'd1);

    // ---------------- FSM and statistics ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            lives_reg     <= LIVES_INIT;
            level_reg     <= LEVEL_FIRST;
            score_reg     <= 12'h000;
            countdown_reg <= CD_START;
            frame_reg     <= '0;
            playing_reg   <= 1'b0;
            go_pulse_reg  <= 1'b0;
            game_over_reg <= 1'b0;
        end else begin
            go_pulse_reg <= 1'b0;
            case (state_reg)
                IDLE, GAME_OVER: begin
                    if (gameStart) begin
                        state_reg     <= COUNTDOWN;
                        lives_reg     <= LIVES_INIT;
                        level_reg     <= LEVEL_FIRST;
                        score_reg     <= 12'h000;
                        countdown_reg <= CD_START;
                        frame_reg     <= '0;
                        playing_reg   <= 1'b0;
                        game_over_reg <= 1'b0;
                    end
                end
                COUNTDOWN: begin
                    if (startOfFrame) begin
                        if (frame_reg == FRAME_LAST) begin
                            frame_reg <= '0;
                            if (countdown_reg == 4'd1) begin
                                countdown_reg <= 4'd0;
                                state_reg     <= PLAY;
                                playing_reg   <= 1'b1;
                                go_pulse_reg  <= 1'b1;
                            end else begin
                                countdown_reg <= countdown_reg - 4'd1;
                            end
                        end else begin
                            frame_reg <= frame_reg + 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (scoreAdd) begin
                        score_reg <= score_next;
                    end
                    if (lose_final) begin
                        lives_reg     <= 4'd0;
                        state_reg     <= GAME_OVER;
                        playing_reg   <= 1'b0;
                        game_over_reg <= 1'b1;
                    end else begin
                        if (lifeGain && !lifeLost) begin
                            lives_reg <= (lives_reg >= LIVES_MAX) ? LIVES_MAX : lives_reg + 4'd1;
                        end else if (lifeLost && !lifeGain && lives_reg != 4'd0) begin
                            lives_reg <= lives_reg - 4'd1;
                        end
                        if (levelUp) begin
                            level_reg     <= level_next;
                            state_reg     <= COUNTDOWN;
                            countdown_reg <= CD_START;
                            frame_reg     <= '0;
                            playing_reg   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign livesDisplay     = lives_reg;
    assign levelDisplay     = level_reg;
    assign scoreDisplay     = score_reg;
    assign countdownDisplay = countdown_reg;
    assign playing          = playing_reg;
    assign goPulse          = go_pulse_reg;
    assign gameOver         = game_over_reg;

endmodule

// File: tb/tb_hud_stats_counter.sv
// tb_hud_stats_counter: directed self-checking bench for hud_stats_counter
// with FRAMES_PER_SEC = 4, COUNTDOWN_START = 3, INIT_LIVES = 3.
// The observed vector packs {lives, level, score, countdown, playing, goPulse, gameOver}.
module tb_hud_stats_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        startOfFrame, gameStart, scoreAdd, levelUp, lifeLost, lifeGain;
    logic [3:0]  scoreAmount;
    logic [3:0]  livesDisplay;
    logic [7:0]  levelDisplay;
    logic [11:0] scoreDisplay;
    logic [3:0]  countdownDisplay;
    logic        playing, goPulse, gameOver;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [30:0] obs;
    logic [30:0] exp_v;

    assign obs = {livesDisplay, levelDisplay, scoreDisplay, countdownDisplay, playing, goPulse, gameOver};

    always #5 clk = ~clk;

    hud_stats_counter #(
        .INIT_LIVES(3), .MAX_LIVES(9), .COUNTDOWN_START(3), .FRAMES_PER_SEC(4)
    ) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .gameStart(gameStart),
        .scoreAdd(scoreAdd), .scoreAmount(scoreAmount), .levelUp(levelUp),
        .lifeLost(lifeLost), .lifeGain(lifeGain),
        .livesDisplay(livesDisplay), .levelDisplay(levelDisplay), .scoreDisplay(scoreDisplay),
        .countdownDisplay(countdownDisplay), .playing(playing), .goPulse(goPulse), .gameOver(gameOver)
    );

    // Apply one cycle of input pulses; returns 1 time unit after the capturing edge.
    task automatic step(input logic sof, input logic gs, input logic sa, input logic [3:0] amt,
                        input logic lu, input logic ll, input logic lg);
        startOfFrame = sof; gameStart = gs; scoreAdd = sa; scoreAmount = amt;
        levelUp = lu; lifeLost = ll; lifeGain = lg;
        @(posedge clk); #1;
        startOfFrame = 0; gameStart = 0; scoreAdd = 0; scoreAmount = 0;
        levelUp = 0; lifeLost = 0; lifeGain = 0;
    endtask

    // Drive frame ticks until goPulse, bounded; go must appear on exactly the 12th tick.
    task automatic run_to_play(input string tag);
        int n = 0;
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            n++;
            if (goPulse === 1'b1) seen = 1;
        end
        total_cnt++;
        if (!seen || n != 12 || playing !== 1'b1)
            $display("FAIL %s go_timing: seen=%0d ticks=%0d playing=%b, want seen=1 ticks=12 playing=1", tag, seen, n, playing);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1;
        step(0, 0, 0, 0, 0, 0, 0);
        reset = 0;
        exp_v = {4'd3, 8'h01, 12'h000, 4'd3, 3'b000};
        total_cnt++;
        if (obs !== exp_v) $display("FAIL reset_values: got %h want %h", obs, exp_v);
        else pass_cnt++;
        // Events in IDLE other than gameStart are ignored.
        step(1, 0, 1, 4'd5, 1, 1, 1);
        total_cnt++;
        if (obs !== exp_v) $display("FAIL idle_ignore: got %h want %h", obs, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_countdown();
        logic [3:0] exp_cd;
        step(0, 1, 0, 0, 0, 0, 0);
        exp_v = {4'd3, 8'h01, 12'h000, 4'd3, 3'b000};
        total_cnt++;
        if (obs !== exp_v) $display("FAIL start_countdown: got %h want %h", obs, exp_v);
        else pass_cnt++;
        for (int k = 1; k <= 12; k++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            exp_cd = 4'(3 - k / 4);
            total_cnt++;
            if (countdownDisplay !== exp_cd || goPulse !== (k == 12) || playing !== (k == 12))
                $display("FAIL countdown_tick%0d: cd=%h go=%b play=%b want cd=%h go=%b play=%b",
                         k, countdownDisplay, goPulse, playing, exp_cd, (k == 12), (k == 12));
            else pass_cnt++;
        end
        step(0, 0, 0, 0, 0, 0, 0);
        exp_v = {4'd3, 8'h01, 12'h000, 4'd0, 3'b100};
        total_cnt++;
        if (obs !== exp_v) $display("FAIL go_single_cycle: got %h want %h", obs, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_score();
        logic [11:0] exp_s [3] = '{12'h009, 12'h018, 12'h023};
        logic [3:0]  amt   [3] = '{4'd9, 4'd9, 4'd5};
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, amt[i], 0, 0, 0);
            total_cnt++;
            if (scoreDisplay !== exp_s[i]) $display("FAIL score_add%0d: got %h want %h", i, scoreDisplay, exp_s[i]);
            else pass_cnt++;
        end
        // 23 + 108*9 = 995
        for (int i = 0; i < 108; i++) step(0, 0, 1, 4'd9, 0, 0, 0);
        total_cnt++;
        if (scoreDisplay !== 12'h995) $display("FAIL score_preset: got %h want 995", scoreDisplay);
        else pass_cnt++;
        step(0, 0, 1, 4'hF, 0, 0, 0);
        total_cnt++;
        if (scoreDisplay !== 12'h999) $display("FAIL score_sat_f: got %h want 999", scoreDisplay);
        else pass_cnt++;
        step(0, 0, 1, 4'd1, 0, 0, 0);
        total_cnt++;
        if (scoreDisplay !== 12'h999) $display("FAIL score_sat_hold: got %h want 999", scoreDisplay);
        else pass_cnt++;
    endtask

    task automatic test_level();
        int lvl = 1;
        logic [7:0] exp_l;
        for (int i = 1; i <= 100; i++) begin
            step(0, 0, 0, 0, 1, 0, 0);
            if (lvl < 99) lvl++;
            exp_l = {4'(lvl / 10), 4'(lvl % 10)};
            total_cnt++;
            if (levelDisplay !== exp_l || countdownDisplay !== 4'd3 || playing !== 1'b0 || livesDisplay !== 4'd3)
                $display("FAIL level_up%0d: lvl=%h cd=%h play=%b lives=%h want lvl=%h cd=3 play=0 lives=3",
                         i, levelDisplay, countdownDisplay, playing, livesDisplay, exp_l);
            else pass_cnt++;
            run_to_play($sformatf("level%0d", i));
        end
        total_cnt++;
        if (levelDisplay !== 8'h99 || scoreDisplay !== 12'h999) $display("FAIL level_final: lvl=%h score=%h want 99/999", levelDisplay, scoreDisplay);
        else pass_cnt++;
    endtask

    task automatic test_lives();
        step(0, 0, 0, 0, 0, 1, 1);
        total_cnt++;
        if (livesDisplay !== 4'd3) $display("FAIL lives_lost_gain: got %h want 3", livesDisplay);
        else pass_cnt++;
        for (int i = 2; i >= 0; i--) begin
            step(0, 0, 0, 0, 0, 1, 0);
            total_cnt++;
            if (livesDisplay !== 4'(i)) $display("FAIL life_lost_to%0d: got %h want %0d", i, livesDisplay, i);
            else pass_cnt++;
        end
        exp_v = {4'd0, 8'h99, 12'h999, 4'd0, 3'b001};
        total_cnt++;
        if (obs !== exp_v) $display("FAIL game_over: got %h want %h", obs, exp_v);
        else pass_cnt++;
        step(1, 0, 1, 4'd3, 1, 1, 1);
        step(1, 0, 1, 4'd3, 0, 0, 1);
        total_cnt++;
        if (obs !== exp_v) $display("FAIL game_over_frozen: got %h want %h", obs, exp_v);
        else pass_cnt++;
        step(0, 1, 0, 0, 0, 0, 0);
        exp_v = {4'd3, 8'h01, 12'h000, 4'd3, 3'b000};
        total_cnt++;
        if (obs !== exp_v) $display("FAIL restart: got %h want %h", obs, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        run_to_play("sim_a");
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        exp_v = {4'd1, 8'h02, 12'h000, 4'd3, 3'b000};
        total_cnt++;
        if (obs !== exp_v) $display("FAIL lost_and_level: got %h want %h", obs, exp_v);
        else pass_cnt++;
        // Score, life and restart events are ignored during COUNTDOWN.
        step(0, 1, 1, 4'd5, 1, 1, 1);
        total_cnt++;
        if (obs !== exp_v) $display("FAIL countdown_ignore: got %h want %h", obs, exp_v);
        else pass_cnt++;
        run_to_play("sim_b");
        step(0, 0, 1, 4'd7, 1, 1, 0);
        exp_v = {4'd0, 8'h02, 12'h007, 4'd0, 3'b001};
        total_cnt++;
        if (obs !== exp_v) $display("FAIL final_lost_drops_level: got %h want %h", obs, exp_v);
        else pass_cnt++;
        step(0, 1, 0, 0, 0, 0, 0);
        run_to_play("sim_c");
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 1);
        total_cnt++;
        if (livesDisplay !== 4'd9) $display("FAIL lives_gain_to9: got %h want 9", livesDisplay);
        else pass_cnt++;
        step(0, 0, 0, 0, 0, 0, 1);
        total_cnt++;
        if (livesDisplay !== 4'd9) $display("FAIL lives_sat: got %h want 9", livesDisplay);
        else pass_cnt++;
        step(0, 1, 0, 0, 0, 0, 0);
        exp_v = {4'd9, 8'h01, 12'h000, 4'd0, 3'b100};
        total_cnt++;
        if (obs !== exp_v) $display("FAIL play_ignores_start: got %h want %h", obs, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        step(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0);
        exp_v = {4'd9, 8'h02, 12'h000, 4'd2, 3'b000};
        total_cnt++;
        if (obs !== exp_v) $display("FAIL mid_countdown: got %h want %h", obs, exp_v);
        else pass_cnt++;
        reset = 1;
        step(1, 1, 1, 4'd9, 1, 1, 1);
        reset = 0;
        exp_v = {4'd3, 8'h01, 12'h000, 4'd3, 3'b000};
        total_cnt++;
        if (obs !== exp_v) $display("FAIL reset_mid: got %h want %h", obs, exp_v);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0);
        total_cnt++;
        if (obs !== exp_v) $display("FAIL idle_frames_ignored: got %h want %h", obs, exp_v);
        else pass_cnt++;
        step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0);
        total_cnt++;
        if (countdownDisplay !== 4'd2) $display("FAIL post_reset_cd: got %h want 2", countdownDisplay);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1;
        startOfFrame = 0; gameStart = 0; scoreAdd = 0; scoreAmount = 0;
        levelUp = 0; lifeLost = 0; lifeGain = 0;
        @(posedge clk); #1;
        test_reset();
        test_countdown();
        test_score();
        test_level();
        test_lives();
        test_simultaneous();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
